// File: rtl/array_reader.sv
// Sequential scan reader: sweeps indices 0..DEPTH-1 through a 1-cycle-latency array read port,
// accumulating a checksum. Define ARRAY_READER_CHECK_EN to build the data==index pattern compare.
module array_reader #(
    parameter int DEPTH   = 32,
    parameter int INDEX_W = 6,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [INDEX_W-1:0] readIndex,
    output logic               readEnable,
    input  logic [DATA_W-1:0]  readData,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  checksum,
    output logic [INDEX_W:0]   mismatchCount,
    output logic [INDEX_W-1:0] firstMismatch
);

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [INDEX_W-1:0] index_reg, index_next;
    logic               rd_en_reg, rd_en_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               clear_results;
    logic               cap_valid_reg;
    logic [DATA_W-1:0]  checksum_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            index_reg <= '0;
            rd_en_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            rd_en_reg <= rd_en_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        rd_en_next    = rd_en_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        clear_results = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    clear_results = 1'b1;
                    state_next    = ISSUE;
                    index_next    = '0;
                    rd_en_next    = 1'b1;
                    busy_next     = 1'b1;
                end
            end
            ISSUE: begin
                // The last index is held rather than wrapped once it has been issued.
                if (index_reg == LAST_INDEX) begin
                    state_next = DRAIN;
                    rd_en_next = 1'b0;
                end else begin
                    index_next = index_reg + 1'b1;
                end
            end
            DRAIN: begin
                state_next = DONE;
                done_next  = 1'b1;
                busy_next  = 1'b0;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture stage: data returned by the array lines up with the delayed read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid_reg <= 1'b0;
            checksum_reg  <= '0;
        end else begin
            cap_valid_reg <= rd_en_reg;
            if (clear_results) begin
                checksum_reg <= '0;
            end else if (cap_valid_reg) begin
                checksum_reg <= checksum_reg + readData;
            end
        end
    end

`ifdef ARRAY_READER_CHECK_EN
    logic [INDEX_W-1:0] key_reg;
    logic [INDEX_W:0]   mismatch_count_reg;
    logic [INDEX_W-1:0] first_mismatch_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg            <= '0;
            mismatch_count_reg <= '0;
            first_mismatch_reg <= '0;
        end else begin
            key_reg <= index_reg;
            if (clear_results) begin
                mismatch_count_reg <= '0;
                first_mismatch_reg <= '0;
            end else if (cap_valid_reg && (readData != DATA_W'(key_reg))) begin
                mismatch_count_reg <= mismatch_count_reg + 1'b1;
                // A zero count means this is the first mismatch of the scan.
                if (mismatch_count_reg == '0) begin
                    first_mismatch_reg <= key_reg;
                end
            end
        end
    end

    assign mismatchCount = mismatch_count_reg;
    assign firstMismatch = first_mismatch_reg;
`else
    assign mismatchCount = '0;
    assign firstMismatch = '0;
`endif

    assign readIndex  = index_reg;
    assign readEnable = rd_en_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign checksum   = checksum_reg;

endmodule

// File: doc/array_reader.md
# array_reader

Sequential scan reader for the test-bench `array` storage block: the reading end of the array write interface. On a start pulse it sweeps every index from 0 to `DEPTH-1` through the array's synchronous read port. It folds each returned word into a checksum and optionally compares each word against the expected fill pattern (data == index). Results are reported with a one-cycle done pulse, and the block sits beside the array writer in the tiny-test harness to close the write/read loop.

## Interface
Parameters:
- `DEPTH`, 32: number of entries scanned; must be ≥ 2 and ≤ 2^`INDEX_W`.
- `INDEX_W`, 6: width of the array index bus.
- `DATA_W`, 32: width of the array data bus.

Ports:
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: scan request; sampled only in IDLE.
- `readIndex`  out  `INDEX_W`: array read address.
- `readEnable`  out  1: read strobe to array.
- `readData`  in  `DATA_W`: array read data, valid the cycle after `readEnable`.
- `busy`  out  1: high from the cycle after an accepted start until `done`.
- `done`  out  1: one-cycle pulse at scan completion.
- `checksum`  out  `DATA_W`: modulo-2^`DATA_W` sum of all words read.
- `mismatchCount`  out  `INDEX_W`+1: number of words ≠ index (check build only).
- `firstMismatch`  out  `INDEX_W`: lowest mismatching index; 0 if none.

## Operation
- Reset values: `readIndex`=0, `readEnable`=0, `busy`=0, `done`=0, `checksum`=0, `mismatchCount`=0, `firstMismatch`=0; FSM in IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE, `start`=1: clear `checksum`, `mismatchCount`, `firstMismatch`; next state ISSUE with `readIndex`=0, `readEnable`=1, `busy`=1.
- ISSUE: one read per cycle. `readIndex` increments by 1 each cycle. When `readIndex`=`DEPTH-1` is issued, the next state is DRAIN.
- DRAIN: `readEnable`=0; captures the last word; next state DONE.
- DONE: `done`=1 and `busy`=0 for exactly one cycle; next state IDLE.
- Capture: in every cycle following a `readEnable`=1 cycle, `readData` is added to `checksum`. A registered copy of the issued index is the compare key.
- Compare (check build): if `readData` ≠ zero-extended key, increment `mismatchCount`. If this is the first mismatch of the scan, load `firstMismatch` with the key.
- Results hold their values from `done` until the next accepted start.
- `start` in any state other than IDLE is ignored and is not queued.
- `rst` asserted mid-scan: all outputs return to reset values at that edge. No partial result is retained.
- The index never wraps: the last address issued is `DEPTH-1`.

## Timing
- Start accepted at edge T0. Read of index k issued in cycle T0+1+k. Its data is captured at edge T0+2+k.
- `readEnable` is high for exactly `DEPTH` consecutive cycles.
- `done` asserts in cycle T0+`DEPTH`+2. A full scan occupies `DEPTH`+2 cycles after acceptance.
- `start` held high continuously re-arms the scan in the cycle after DONE (the IDLE cycle). Back-to-back scan period is `DEPTH`+3 cycles.
- Array read latency is fixed at 1 cycle. Outputs are registered, with no combinational path from `readData` to any output.

## Configuration
- `ARRAY_READER_CHECK_EN` defined: the pattern compare logic is built. `mismatchCount` and `firstMismatch` behave as described.
- `ARRAY_READER_CHECK_EN` undefined: the compare logic is removed. `mismatchCount` and `firstMismatch` are tied to 0. Checksum, FSM and timing are identical in both builds.

## Test plan
- Array pre-filled with data=i for i=0..31; pulse `start` -> `done` at T0+34, `checksum`=496, `mismatchCount`=0, `firstMismatch`=0.
- Array filled with data=i except entries 5=100 and 20=0 -> `checksum`=571, `mismatchCount`=2, `firstMismatch`=5. Without the macro, both check outputs stay 0 and `checksum` is still 571.
- `start` pulsed again at scan cycle 10 -> ignored; exactly 32 `readEnable` cycles, one `done`.
- `rst` asserted at scan cycle 15 -> next cycle all outputs 0, state IDLE. A following start completes normally with `checksum`=496.
- All entries 0xFFFFFFFF -> `checksum`=0xFFFFFFE0 (wrap), `mismatchCount`=32, `firstMismatch`=0.
- `start` held high for 80 cycles -> `done` pulses at T0+34 and T0+69, `readIndex` sequence 0..31 each scan.
